// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding,
// FSM state encodings and the pc increment helper.
package if_stage_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory request/response bus between the fetch stage (master)
// and the instruction memory (slave). One request outstanding at a time.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_hold_buf.sv
// One-entry {pc, instr} skid buffer that parks a fetch response which
// arrived while the IF/ID register was stalled.
module if_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  logic [63:0] entry;

  // Clear wins over load so a redirect always discards the parked entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= {pc_in, instr_in};
    end
  end

  assign pc    = entry[63:32];
  assign instr = entry[31:0];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues single-outstanding fetches to imem,
// fills the IF/ID register, parks responses while stalled, and handles
// redirects (dropping any in-flight response).
// Optional feature: define IF_MISALIGN_CHK_EN to report misaligned
// redirect targets as a faulting IF/ID entry instead of aligning them.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  imem,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic        misalign_out
);

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] fetch_pc;
  logic        mis_pend;   // misaligned entry waiting to be written to IF/ID
  logic        halt;       // parked in IDLE after a misaligned redirect

  logic [31:0] redir_tgt;
  logic        redir_mis;

`ifdef IF_MISALIGN_CHK_EN
  assign redir_tgt = redirect_pc;
  assign redir_mis = |redirect_pc[1:0];
`else
  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign redir_mis = 1'b0;
`endif

  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic        buf_load;
  logic        buf_clear;
  logic        deliver_resp;
  logic        deliver_buf;
  logic        deliver_mis;

  assign deliver_resp = (state == S_WAIT) && imem.imem_rvalid && !stall;
  assign deliver_buf  = (state == S_HOLD) && buf_valid && !stall;
  assign deliver_mis  = (state == S_IDLE) && mis_pend && !stall;
  assign buf_load     = !redirect_valid && (state == S_WAIT) && imem.imem_rvalid && stall;
  assign buf_clear    = redirect_valid || deliver_buf;

  if_hold_buf u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .clear    (buf_clear),
    .pc_in    (fetch_pc),
    .instr_in (imem.imem_rdata),
    .valid    (buf_valid),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  // Address is the pc register itself, so it only moves on grant or redirect.
  assign imem.imem_req  = (state == S_REQ);
  assign imem.imem_addr = pc_reg;

  // Fetch FSM plus IF/ID register; redirect outranks stall and everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc_reg       <= RESET_PC;
      fetch_pc     <= RESET_PC;
      mis_pend     <= 1'b0;
      halt         <= 1'b0;
      pc_out       <= '0;
      pc_plus4_out <= '0;
      instr_out    <= NOP;
      valid_out    <= 1'b0;
      misalign_out <= 1'b0;
    end else if (redirect_valid) begin
      pc_reg       <= redir_tgt;
      instr_out    <= NOP;
      valid_out    <= 1'b0;
      misalign_out <= 1'b0;
      if (redir_mis) begin
        state    <= S_IDLE;
        mis_pend <= 1'b1;
        halt     <= 1'b1;
      end else begin
        mis_pend <= 1'b0;
        halt     <= 1'b0;
        case (state)
          S_WAIT:  state <= imem.imem_rvalid ? S_REQ : S_DROP;
          S_REQ:   state <= imem.imem_gnt    ? S_DROP : S_REQ;
          S_DROP:  state <= imem.imem_rvalid ? S_REQ : S_DROP;
          default: state <= S_REQ;
        endcase
      end
    end else begin
      if (!stall) begin
        if (deliver_resp) begin
          pc_out       <= fetch_pc;
          pc_plus4_out <= pc_inc(fetch_pc);
          instr_out    <= imem.imem_rdata;
          valid_out    <= 1'b1;
          misalign_out <= 1'b0;
        end else if (deliver_buf) begin
          pc_out       <= buf_pc;
          pc_plus4_out <= pc_inc(buf_pc);
          instr_out    <= buf_instr;
          valid_out    <= 1'b1;
          misalign_out <= 1'b0;
        end else if (deliver_mis) begin
          pc_out       <= pc_reg;
          pc_plus4_out <= pc_inc(pc_reg);
          instr_out    <= NOP;
          valid_out    <= 1'b1;
          misalign_out <= 1'b1;
          mis_pend     <= 1'b0;
        end else begin
          instr_out    <= NOP;
          valid_out    <= 1'b0;
          misalign_out <= 1'b0;
        end
      end
      case (state)
        S_IDLE: if (!halt) state <= S_REQ;
        S_REQ: begin
          if (imem.imem_gnt) begin
            fetch_pc <= pc_reg;
            pc_reg   <= pc_inc(pc_reg);
            state    <= S_WAIT;
          end
        end
        S_WAIT: if (imem.imem_rvalid) state <= stall ? S_HOLD : S_REQ;
        S_HOLD: if (!stall) state <= S_REQ;
        S_DROP: if (imem.imem_rvalid) state <= S_REQ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage. A second instance with
// RESET_PC=FFFF_FFFC exercises pc wrap-around.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_out, pc_plus4_out, instr_out;
  logic        valid_out, misalign_out;

  logic        rst2_n = 1'b0;
  logic        stall2 = 1'b0;
  logic        redir2 = 1'b0;
  logic [31:0] redir2_pc = '0;
  logic [31:0] pc2, pc2_p4, instr2;
  logic        valid2, mis2;

  int checks = 0;
  int errors = 0;

  if_stage_if imem();
  if_stage_if imem2();

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(imem),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .instr_out(instr_out),
    .valid_out(valid_out), .misalign_out(misalign_out)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst2_n), .stall(stall2),
    .redirect_valid(redir2), .redirect_pc(redir2_pc),
    .imem(imem2),
    .pc_out(pc2), .pc_plus4_out(pc2_p4), .instr_out(instr2),
    .valid_out(valid2), .misalign_out(mis2)
  );

  function automatic logic [31:0] mk_instr(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    cyc(); cyc();
    checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", imem.imem_req); end
    checks++; if (imem.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem.imem_addr); end
    checks++; if (pc_out !== 32'h0 || pc_plus4_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h/%h exp 0/0", pc_out, pc_plus4_out); end
    checks++; if (instr_out !== NOP || valid_out !== 1'b0 || misalign_out !== 1'b0) begin errors++; $display("FAIL rst_ifid got %h %b %b exp %h 0 0", instr_out, valid_out, misalign_out, NOP); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_zero_wait();
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'(4*k)) begin errors++; $display("FAIL zw_issue%0d got %b %h exp 1 %h", k, imem.imem_req, imem.imem_addr, 32'(4*k)); end
      imem.imem_gnt = 1'b1;
      cyc();
      checks++; if (imem.imem_req !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL zw_wait%0d got req %b valid %b exp 0 0", k, imem.imem_req, valid_out); end
      imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = mk_instr(32'(4*k));
      cyc();
      imem.imem_rvalid = 1'b0;
      checks++; if (valid_out !== 1'b1 || pc_out !== 32'(4*k) || pc_plus4_out !== 32'(4*k+4) || instr_out !== mk_instr(32'(4*k))) begin
        errors++; $display("FAIL zw_out%0d got %b %h %h %h exp 1 %h %h %h", k, valid_out, pc_out, pc_plus4_out, instr_out, 32'(4*k), 32'(4*k+4), mk_instr(32'(4*k)));
      end
    end
  endtask

  task automatic test_stall();
    imem.imem_gnt = 1'b1; cyc();
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = mk_instr(32'hC); cyc();
    imem.imem_rvalid = 1'b0;
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'hC) begin errors++; $display("FAIL st_pre got %b %h exp 1 0000000c", valid_out, pc_out); end
    stall = 1'b1; imem.imem_gnt = 1'b1; cyc();
    imem.imem_gnt = 1'b0;
    checks++; if (dut.state !== S_WAIT || valid_out !== 1'b1 || pc_out !== 32'hC) begin errors++; $display("FAIL st_issue got %0d %b %h exp WAIT 1 0000000c", dut.state, valid_out, pc_out); end
    imem.imem_rvalid = 1'b1; imem.imem_rdata = mk_instr(32'h10); cyc();
    imem.imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dut.state !== S_HOLD || imem.imem_req !== 1'b0 || valid_out !== 1'b1 || pc_out !== 32'hC || instr_out !== mk_instr(32'hC)) begin
        errors++; $display("FAIL st_hold%0d got %0d %b %b %h %h exp HOLD 0 1 0000000c %h", i, dut.state, imem.imem_req, valid_out, pc_out, instr_out, mk_instr(32'hC));
      end
      if (i == 2) stall = 1'b0;
      cyc();
    end
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h10 || instr_out !== mk_instr(32'h10) || pc_plus4_out !== 32'h14) begin
      errors++; $display("FAIL st_release got %b %h %h %h exp 1 00000010 %h 00000014", valid_out, pc_out, instr_out, pc_plus4_out, mk_instr(32'h10));
    end
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h14) begin errors++; $display("FAIL st_next got %b %h exp 1 00000014", imem.imem_req, imem.imem_addr); end
  endtask

  task automatic test_redirect_drop();
    redirect_valid = 1'b1; redirect_pc = 32'h8; cyc();
    redirect_valid = 1'b0;
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h8 || valid_out !== 1'b0) begin errors++; $display("FAIL rd_req got %b %h %b exp 1 00000008 0", imem.imem_req, imem.imem_addr, valid_out); end
    imem.imem_gnt = 1'b1; cyc();
    imem.imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; cyc();
    redirect_valid = 1'b0;
    checks++; if (dut.state !== S_DROP || imem.imem_req !== 1'b0) begin errors++; $display("FAIL rd_drop got %0d %b exp DROP 0", dut.state, imem.imem_req); end
    imem.imem_rvalid = 1'b1; imem.imem_rdata = mk_instr(32'h8); cyc();
    imem.imem_rvalid = 1'b0;
    checks++; if (valid_out !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100) begin errors++; $display("FAIL rd_discard got %b %b %h exp 0 1 00000100", valid_out, imem.imem_req, imem.imem_addr); end
    imem.imem_gnt = 1'b1; cyc();
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = mk_instr(32'h100); cyc();
    imem.imem_rvalid = 1'b0;
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h100 || instr_out !== mk_instr(32'h100)) begin errors++; $display("FAIL rd_target got %b %h %h exp 1 00000100 %h", valid_out, pc_out, instr_out, mk_instr(32'h100)); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; cyc();
    redirect_valid = 1'b0;
    checks++; if (valid_out !== 1'b0 || instr_out !== NOP || imem.imem_addr !== 32'h40 || imem.imem_req !== 1'b1) begin
      errors++; $display("FAIL rs_clear got %b %h %h %b exp 0 %h 00000040 1", valid_out, instr_out, imem.imem_addr, imem.imem_req, NOP);
    end
    stall = 1'b0;
    imem.imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; cyc();
    imem.imem_gnt = 1'b0; redirect_valid = 1'b0;
    checks++; if (dut.state !== S_DROP || imem.imem_req !== 1'b0) begin errors++; $display("FAIL rs_gnt_drop got %0d %b exp DROP 0", dut.state, imem.imem_req); end
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h1234_5678; cyc();
    imem.imem_rvalid = 1'b0;
    checks++; if (valid_out !== 1'b0 || dut.state !== S_REQ || imem.imem_addr !== 32'h80) begin errors++; $display("FAIL rs_resume got %b %0d %h exp 0 REQ 00000080", valid_out, dut.state, imem.imem_addr); end
    imem.imem_rvalid = 1'b1; cyc();
    imem.imem_rvalid = 1'b0;
    checks++; if (valid_out !== 1'b0 || dut.state !== S_REQ) begin errors++; $display("FAIL rs_stray got %b %0d exp 0 REQ", valid_out, dut.state); end
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1; imem.imem_gnt = 1'b1; cyc();
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = mk_instr(32'h80); cyc();
    imem.imem_rvalid = 1'b0;
    checks++; if (dut.state !== S_HOLD) begin errors++; $display("FAIL rh_hold got %0d exp HOLD", dut.state); end
    redirect_valid = 1'b1; redirect_pc = 32'h180; cyc();
    redirect_valid = 1'b0; stall = 1'b0;
    checks++; if (dut.state !== S_REQ || imem.imem_addr !== 32'h180 || valid_out !== 1'b0) begin errors++; $display("FAIL rh_redir got %0d %h %b exp REQ 00000180 0", dut.state, imem.imem_addr, valid_out); end
    cyc();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rh_discard got %b exp 0", valid_out); end
  endtask

`ifdef IF_MISALIGN_CHK_EN
  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102; cyc();
    redirect_valid = 1'b0;
    checks++; if (imem.imem_req !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL ma_noreq got %b %b exp 0 0", imem.imem_req, valid_out); end
    cyc();
    checks++; if (valid_out !== 1'b1 || misalign_out !== 1'b1 || pc_out !== 32'h102 || instr_out !== NOP || imem.imem_req !== 1'b0) begin
      errors++; $display("FAIL ma_entry got %b %b %h %h %b exp 1 1 00000102 %h 0", valid_out, misalign_out, pc_out, instr_out, imem.imem_req, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (imem.imem_req !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL ma_park%0d got %b %b exp 0 0", i, imem.imem_req, valid_out); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200; cyc();
    redirect_valid = 1'b0;
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h200 || misalign_out !== 1'b0) begin errors++; $display("FAIL ma_resume got %b %h %b exp 1 00000200 0", imem.imem_req, imem.imem_addr, misalign_out); end
  endtask
`else
  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102; cyc();
    redirect_valid = 1'b0;
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100 || misalign_out !== 1'b0 || valid_out !== 1'b0) begin
      errors++; $display("FAIL ma_align got %b %h %b %b exp 1 00000100 0 0", imem.imem_req, imem.imem_addr, misalign_out, valid_out);
    end
  endtask
`endif

  task automatic test_reset_mid();
    imem.imem_gnt = 1'b1; cyc();
    imem.imem_gnt = 1'b0;
    rst_n = 1'b0; #1;
    checks++; if (imem.imem_req !== 1'b0 || imem.imem_addr !== 32'h0 || valid_out !== 1'b0 || pc_out !== 32'h0 || pc_plus4_out !== 32'h0 || instr_out !== NOP || misalign_out !== 1'b0) begin
      errors++; $display("FAIL rm_async got %b %h %b %h %h %h %b exp 0 0 0 0 0 %h 0", imem.imem_req, imem.imem_addr, valid_out, pc_out, pc_plus4_out, instr_out, misalign_out, NOP);
    end
    cyc();
    rst_n = 1'b1; cyc();
    checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0 || dut.state !== S_REQ) begin errors++; $display("FAIL rm_restart got %b %h %0d exp 1 0 REQ", imem.imem_req, imem.imem_addr, dut.state); end
  endtask

  task automatic test_reset_pc_wrap();
    imem2.imem_gnt = 1'b1; imem2.imem_rvalid = 1'b1; imem2.imem_rdata = 32'hCAFE_0001;
    rst2_n = 1'b1; cyc();
    checks++; if (imem2.imem_req !== 1'b1 || imem2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_first got %b %h exp 1 fffffffc", imem2.imem_req, imem2.imem_addr); end
    cyc();
    cyc();
    checks++; if (imem2.imem_req !== 1'b1 || imem2.imem_addr !== 32'h0) begin errors++; $display("FAIL wr_second got %b %h exp 1 00000000", imem2.imem_req, imem2.imem_addr); end
    checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || pc2_p4 !== 32'h0 || instr2 !== 32'hCAFE_0001) begin
      errors++; $display("FAIL wr_out got %b %h %h %h exp 1 fffffffc 00000000 cafe0001", valid2, pc2, pc2_p4, instr2);
    end
  endtask

  initial begin
    imem2.imem_gnt = 1'b0; imem2.imem_rvalid = 1'b0; imem2.imem_rdata = '0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_drop();
    test_redirect_stall();
    test_redirect_hold();
    test_misalign();
    test_reset_mid();
    test_reset_pc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
